// File: rtl/spi_master_rw.sv
// Parametrised SPI master: configurable width, divider, CS count and mode.
// Chip select can be held across words and released explicitly when idle.
module spi_master_rw #(
  parameter int WIDTH = 8,
  parameter int NCS   = 1,
  parameter int DIV   = 2,
  parameter bit CPOL  = 1'b0,
  parameter bit CPHA  = 1'b0,
  localparam int CSW  = (NCS > 1) ? $clog2(NCS) : 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             write,
  input  logic [WIDTH:0]   din,
  input  logic [CSW-1:0]   cs_sel,
  input  logic             cs_release,
  output logic [WIDTH-1:0] dout,
  output logic             busy,
  output logic             done,
  output logic [NCS-1:0]   cs,
  output logic             sck,
  output logic             mosi,
  input  logic             miso
);

  localparam int EW = $clog2(2 * WIDTH) + 1;
  localparam logic [7:0]    CMAX   = 8'(DIV - 1);
  localparam logic [EW-1:0] EMAX   = EW'(2 * WIDTH - 1);
  localparam logic [NCS-1:0] CS_OFF = '1;

  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_t;

  state_t           state, state_nx;
  logic             start_q;
  logic             hold_q;
  logic [CSW-1:0]   sel_q;
  logic [WIDTH-1:0] tx_q;
  logic [WIDTH-1:0] rx_q;
  logic [7:0]       cnt_q;
  logic [EW-1:0]    edge_q;
  logic             tick;
  logic             last_edge;
  logic             lead;
  logic             accept;
  logic             finish;
  logic             launch;

  // Out-of-range selects shift the zero away, leaving every CS high.
  function automatic logic [NCS-1:0] sel_cs(input logic [CSW-1:0] s);
    return ~(NCS'(1) << s);
  endfunction

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  if (start_q) state_nx = SETUP;
      SETUP: if (tick) state_nx = SHIFT;
      SHIFT: if (tick && last_edge) state_nx = HOLD;
      HOLD:  if (tick) state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state != IDLE);
    tick      = (cnt_q == CMAX);
    last_edge = (edge_q == EMAX);
    lead      = ~edge_q[0];
    accept    = write && (state == IDLE) && !start_q;
    launch    = (state == IDLE) && start_q;
    finish    = (state == HOLD) && tick;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      start_q <= 1'b0;
      hold_q  <= 1'b0;
      sel_q   <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
      cnt_q   <= '0;
      edge_q  <= '0;
      cs      <= CS_OFF;
      sck     <= CPOL;
      mosi    <= 1'b0;
      done    <= 1'b0;
      dout    <= '0;
    end else begin
      done <= finish;

      if (state == IDLE || tick) cnt_q <= '0;
      else                       cnt_q <= cnt_q + 8'd1;

      // A write in the same cycle as cs_release takes priority.
      if (accept) begin
        start_q <= 1'b1;
        tx_q    <= din[WIDTH-1:0];
        sel_q   <= cs_sel;
        hold_q  <= din[WIDTH];
      end else if (cs_release && state == IDLE && !start_q) begin
        cs     <= CS_OFF;
        hold_q <= 1'b0;
      end

      if (launch) begin
        start_q <= 1'b0;
        cs      <= sel_cs(sel_q);
        rx_q    <= '0;
        edge_q  <= '0;
        if (!CPHA) begin
          mosi <= tx_q[WIDTH-1];
          tx_q <= tx_q << 1;
        end
      end

      if (state == SHIFT && tick) begin
        sck    <= ~sck;
        edge_q <= edge_q + 1'b1;
        if (lead) begin
          if (CPHA) begin
            mosi <= tx_q[WIDTH-1];
            tx_q <= tx_q << 1;
          end else begin
            rx_q <= (rx_q << 1) | WIDTH'(miso);
          end
        end else begin
          if (CPHA) begin
            rx_q <= (rx_q << 1) | WIDTH'(miso);
          end else if (!last_edge) begin
            mosi <= tx_q[WIDTH-1];
            tx_q <= tx_q << 1;
          end
        end
      end

      if (finish) begin
        dout <= rx_q;
        if (!hold_q) cs <= CS_OFF;
      end
    end
  end

endmodule

// File: tb/tb_spi_master_rw.sv
// Bench for spi_master_rw: mode 0 (NCS=4) and mode 3 (NCS=3) instances
// driven in parallel and checked against a word-level transfer model.
module tb_spi_master_rw;

  localparam int LAT = 1 + 2 * (2 * 8 + 2);

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       write = 1'b0;
  logic       cs_release = 1'b0;
  logic       tie1 = 1'b0;
  logic [8:0] din = '0;
  logic [1:0] cs_sel = '0;

  logic [7:0] dout0, dout3;
  logic       busy0, busy3, done0, done3;
  logic       sck0, sck3, mosi0, mosi3, miso0, miso3;
  logic [3:0] cs0;
  logic [2:0] cs3;

  int checks = 0;
  int failures = 0;
  logic [3:0] exp_cs0 = 4'hF;
  logic [2:0] exp_cs3 = 3'h7;

  assign miso0 = mosi0;
  assign miso3 = tie1 ? 1'b1 : mosi3;

  always #5 clock = ~clock;

  spi_master_rw #(
    .WIDTH(8), .NCS(4), .DIV(2), .CPOL(1'b0), .CPHA(1'b0)
  ) u0 (
    .clock(clock), .reset(reset), .write(write), .din(din),
    .cs_sel(cs_sel), .cs_release(cs_release), .dout(dout0),
    .busy(busy0), .done(done0), .cs(cs0), .sck(sck0),
    .mosi(mosi0), .miso(miso0)
  );

  spi_master_rw #(
    .WIDTH(8), .NCS(3), .DIV(2), .CPOL(1'b1), .CPHA(1'b1)
  ) u3 (
    .clock(clock), .reset(reset), .write(write), .din(din),
    .cs_sel(cs_sel), .cs_release(cs_release), .dout(dout3),
    .busy(busy3), .done(done3), .cs(cs3), .sck(sck3),
    .mosi(mosi3), .miso(miso3)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Active-low select vector for a given index and CS count.
  function automatic logic [3:0] csv(input int sel, input int ncs);
    logic [3:0] v;
    v = 4'hF;
    if (sel < ncs) v[sel] = 1'b0;
    return v;
  endfunction

  // One full transfer on both instances; bw = extra write while busy,
  // br = cs_release while busy, rw = cs_release together with the write.
  task automatic xfer(input logic [7:0] d, input int sel, input bit hold,
                      input bit tied, input bit bw, input bit br,
                      input bit rw);
    logic [3:0] dur0, aft0, dur3, aft3;
    logic [7:0] bits0, bits3;
    int r0, r3, cyc, e_cs, e_bs, extra;
    logic p0, p3;
    dur0 = csv(sel, 4);
    aft0 = hold ? dur0 : 4'hF;
    dur3 = csv(sel, 3);
    aft3 = hold ? dur3 : 4'hF;
    bits0 = '0; bits3 = '0;
    r0 = 0; r3 = 0; e_cs = 0; e_bs = 0;
    @(negedge clock);
    write = 1'b1;
    din = {hold, d};
    cs_sel = 2'(sel);
    tie1 = tied;
    cs_release = rw;
    @(negedge clock);
    write = 1'b0;
    cs_release = 1'b0;
    cyc = 0;
    chk("cs0_edge0", cs0, exp_cs0);
    chk("cs3_edge0", cs3, exp_cs3);
    chk("busy_edge0", busy0, 1'b0);
    p0 = sck0;
    p3 = sck3;
    while (!done0 && cyc < LAT + 20) begin
      if (bw && cyc == 10) begin
        write = 1'b1;
        din = {1'b0, ~d};
      end
      if (bw && cyc == 11) write = 1'b0;
      if (br && cyc == 12) cs_release = 1'b1;
      if (br && cyc == 13) cs_release = 1'b0;
      @(negedge clock);
      cyc++;
      if (sck0 && !p0) begin bits0 = {bits0[6:0], mosi0}; r0++; end
      if (sck3 && !p3) begin bits3 = {bits3[6:0], mosi3}; r3++; end
      p0 = sck0;
      p3 = sck3;
      if (!done0) begin
        if (cs0 !== dur0 || cs3 !== dur3[2:0]) e_cs++;
        if (busy0 !== 1'b1 || busy3 !== 1'b1) e_bs++;
      end
    end
    chk("latency", cyc, LAT);
    chk("done3", done3, 1'b1);
    chk("busy0_done", busy0, 1'b0);
    chk("busy3_done", busy3, 1'b0);
    chk("dout0", dout0, d);
    chk("dout3", dout3, tied ? 8'hFF : d);
    chk("cs0_after", cs0, aft0);
    chk("cs3_after", cs3, aft3[2:0]);
    chk("mosi0_bits", bits0, d);
    chk("mosi3_bits", bits3, d);
    chk("sck0_rises", r0, 8);
    chk("sck3_rises", r3, 8);
    chk("cs_during", e_cs, 0);
    chk("busy_during", e_bs, 0);
    chk("sck0_idle", sck0, 1'b0);
    chk("sck3_idle", sck3, 1'b1);
    @(negedge clock);
    chk("done0_pulse", done0, 1'b0);
    chk("done3_pulse", done3, 1'b0);
    if (bw) begin
      extra = 0;
      repeat (40) begin
        @(negedge clock);
        if (done0 || done3) extra++;
      end
      chk("single_done", extra, 0);
    end
    exp_cs0 = aft0;
    exp_cs3 = aft3[2:0];
  endtask

  initial begin
    int r, cyc, extra;
    logic p;
    logic [7:0] d;

    repeat (2) @(negedge clock);
    chk("rst_cs0", cs0, 4'hF);
    chk("rst_cs3", cs3, 3'h7);
    chk("rst_sck0", sck0, 1'b0);
    chk("rst_sck3", sck3, 1'b1);
    chk("rst_busy", busy0, 1'b0);
    chk("rst_done", done0, 1'b0);
    chk("rst_dout", dout0, 8'h00);
    reset = 1'b0;

    // Mode 0 loopback and mode 3 with miso tied high.
    xfer(8'hA5, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    xfer(8'h3C, 0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

    // CS held across two words on the same select.
    xfer(8'hF0, 2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    xfer(8'h0F, 2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Held select switches; release while busy has no effect.
    xfer(8'($urandom), 1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    xfer(8'($urandom), 3, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("held_sel3", cs0, 4'b0111);

    @(negedge clock);
    cs_release = 1'b1;
    @(negedge clock);
    cs_release = 1'b0;
    chk("release_cs0", cs0, 4'hF);
    chk("release_cs3", cs3, 3'h7);
    exp_cs0 = 4'hF;
    exp_cs3 = 3'h7;

    // Write while busy ignored.
    xfer(8'($urandom), 0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);

    // Release coinciding with a write is dropped.
    xfer(8'($urandom), 1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    xfer(8'($urandom), 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    for (int i = 0; i < 6; i++) begin
      xfer(8'($urandom), int'($urandom_range(0, 3)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           1'b0, 1'b0, 1'b0);
    end

    // Async reset in the middle of the shift phase.
    @(negedge clock);
    write = 1'b1;
    din = {1'b0, 8'h5A};
    cs_sel = 2'd0;
    @(negedge clock);
    write = 1'b0;
    r = 0;
    cyc = 0;
    p = sck0;
    while (r < 4 && cyc < 100) begin
      @(negedge clock);
      cyc++;
      if (sck0 && !p) r++;
      p = sck0;
    end
    chk("reach_bit4", r, 4);
    #2 reset = 1'b1;
    #1;
    chk("arst_cs0", cs0, 4'hF);
    chk("arst_cs3", cs3, 3'h7);
    chk("arst_sck0", sck0, 1'b0);
    chk("arst_sck3", sck3, 1'b1);
    chk("arst_mosi0", mosi0, 1'b0);
    chk("arst_mosi3", mosi3, 1'b0);
    chk("arst_busy0", busy0, 1'b0);
    chk("arst_busy3", busy3, 1'b0);
    chk("arst_done0", done0, 1'b0);
    chk("arst_dout0", dout0, 8'h00);
    chk("arst_dout3", dout3, 8'h00);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    exp_cs0 = 4'hF;
    exp_cs3 = 3'h7;
    extra = 0;
    repeat (50) begin
      @(negedge clock);
      if (done0 || done3) extra++;
    end
    chk("no_done_after_rst", extra, 0);

    d = 8'($urandom);
    xfer(d, 2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
